serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
Parallel-to-serial frame transmitter. It is the driving end of a single-bit serial line whose receiving end samples the line with a dff.
- Accepts a DATA_W word on a valid/ready handshake.
- Emits a framed bit stream, LSB first: start bit (0), data bits, stop bit(s) (1). Each bit is held for CLKS_PER_BIT clocks.
- Sits between a parallel producer and the serial line. The line idles high.

Parameters:
DATA_W, 8, payload width in bits (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  single system clock; all state changes on its rising edge
rst  input  1  asynchronous, active-low reset; 0 resets immediately, independent of clk
tx_data  input  DATA_W  word to transmit; sampled only on handshake
tx_valid  input  1  producer has a word
tx_ready  output  1  block can accept a word (high only in IDLE)
tx_out  output  1  serial line; 1 when idle
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-cycle pulse after a frame completes

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE, tx_out=1, tx_ready=1, busy=0, done=0, shift register=0, bit and cycle counters=0.
- States are IDLE, START, DATA, STOP, plus PARITY when the optional feature is enabled.
- All outputs are registered or decoded from registered state; there is no combinational path from tx_valid or tx_data to any output.
- Handshake:
  - A transfer occurs on a rising edge where tx_valid=1 and tx_ready=1.
  - At that edge tx_data is captured into the shift register and the state moves IDLE->START.
  - tx_valid while busy is ignored; the producer holds it until tx_ready.
- START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx_out = shift_reg[0] for CLKS_PER_BIT cycles, then shift right.
  - After DATA_W bits, go to STOP (or PARITY if enabled).
- STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE with done=1 for exactly that one IDLE cycle.
- Frame timing:
  - tx_out leaves idle on the cycle after the accepting edge.
  - Frame length is (1+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles.
  - tx_ready is high in the first IDLE cycle, concurrent with done.
  - Back-to-back frames with tx_valid held high are separated by exactly one idle cycle.
- Cycle counter: runs 0..CLKS_PER_BIT-1, width $clog2 of CLKS_PER_BIT with a minimum of 1 bit. It wraps to 0 on each bit boundary. With CLKS_PER_BIT=1 each bit lasts exactly one cycle.
- Bit counter: counts 0..DATA_W-1 and is cleared on entry to DATA.
- Changing tx_data mid-frame has no effect on the current frame.
- Reset mid-frame: frame abandoned, tx_out=1 immediately, no done pulse. On release, the block is in IDLE with tx_ready=1.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx_out = XOR of the captured word (even parity) for CLKS_PER_BIT cycles. Frame length becomes (2+DATA_W+STOP_BITS)*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Decomposition:
- Package serial_tx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - localparam IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- Sub-module bit_timer:
  - Ports: clk, rst, clear, tick.
  - Counts to CLKS_PER_BIT-1 and asserts tick on the last cycle of each bit.
  - The FSM advances on tick.

Test Plan:
All scenarios use DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1.
1. Hold rst=0 for 3 cycles, driving tx_valid=1 and tx_data=0xFF -> tx_out=1, tx_ready=1, busy=0, done=0 throughout; no transfer.
2. Send 0xA5 -> tx_out holds 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 cycles); busy=1 for those 40 cycles; done=1 and tx_ready=1 on cycle 41 only.
3. Hold tx_valid=1 with 0x00, then 0xFF presented at the second handshake -> frame 0x00 (0, eight 0s, 1), one idle cycle with tx_out=1, then frame 0xFF (0, eight 1s, 1); two done pulses 41 cycles apart.
4. Start 0x3C and assert rst=0 during data bit 3 -> tx_out=1 in the same cycle, no done pulse; after release, tx_ready=1 and a new 0x5A frame transmits correctly.
5. Start 0x81, then change tx_data to 0x00 and pulse tx_valid mid-frame -> line still shows 0,1,0,0,0,0,0,0,1,1; no second frame starts.
6. With SERIAL_TX_PARITY_EN, send 0x07 -> parity bit 1 appears after data bit 7 for 4 cycles; frame is 44 cycles; done fires on cycle 45.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial_tx frame transmitter.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Counter width for a range of v values, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer for serial_tx: counts 0..CLKS_PER_BIT-1 and raises tick
// on the last cycle of each bit. clear holds the count at zero.
module bit_timer
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W = clog2_min1(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Last cycle of the current bit period.
    always_comb tick = (cnt_q == LAST);

    // Next count: wrap at the bit boundary, hold at zero while cleared.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W data bits LSB
// first, STOP_BITS stop bits, each held for CLKS_PER_BIT clocks.
// Optional even-parity bit before the stop bits: define SERIAL_TX_PARITY_EN.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int              BIT_W     = clog2_min1(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_d;
    logic              done_q;
    logic              done_d;
    logic              tick;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q;
    logic              par_d;
`endif

    // Bit timer is held at zero in IDLE so every frame starts on a fresh period.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    // Next-state logic; the bit counter also counts stop bits.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shift_d   = tx_data;
                    bit_cnt_d = '0;
                    state_d   = START;
`ifdef SERIAL_TX_PARITY_EN
                    par_d     = ^tx_data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, data and pulse registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        tx_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
        done     = done_q;
        case (state_q)
            START:   tx_out = START_LEVEL;
            DATA:    tx_out = shift_q[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  tx_out = par_q;
`endif
            STOP:    tx_out = STOP_LEVEL;
            default: tx_out = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed testbench for serial_tx (DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1).
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 10 + PB;   // bits per frame
    localparam int FC = NB * 4;    // cycles per frame

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_out;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    serial_tx #(
        .DATA_W(8),
        .CLKS_PER_BIT(4),
        .STOP_BITS(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_out  (tx_out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        rst      = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: out=%b rdy=%b busy=%b done=%b, required 1 1 0 0",
                         i, tx_out, tx_ready, busy, done);
            end
        end
        tx_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b rdy=%b, required 0 1", busy, tx_ready);
        end
    endtask

    task automatic test_single_a5();
        logic [0:NB-1] seq;
`ifdef SERIAL_TX_PARITY_EN
        seq = 11'b01010010101;
`else
        seq = 10'b0101001011;
`endif
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int i = 0; i < FC; i++) begin
            n_tests++;
            if (tx_out !== seq[i/4] || busy !== 1'b1 || done !== 1'b0 || tx_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL a5_frame cyc%0d: out=%b busy=%b done=%b rdy=%b, required out=%b 1 0 0",
                         i + 1, tx_out, busy, done, tx_ready, seq[i/4]);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (done !== 1'b1 || tx_ready !== 1'b1 || tx_out !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL a5_done: done=%b rdy=%b out=%b busy=%b, required 1 1 1 0",
                     done, tx_ready, tx_out, busy);
        end
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL a5_done_width: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:NB-1] s0;
        logic [0:NB-1] s1;
        int d1;
        int d2;
`ifdef SERIAL_TX_PARITY_EN
        s0 = 11'b00000000001;
        s1 = 11'b01111111101;
`else
        s0 = 10'b0000000001;
        s1 = 10'b0111111111;
`endif
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_data = 8'hFF;
        for (int i = 0; i < FC; i++) begin
            n_tests++;
            if (tx_out !== s0[i/4]) begin
                n_fail++;
                $display("FAIL b2b_frame0 cyc%0d: out=%b, required %b", i + 1, tx_out, s0[i/4]);
            end
            @(posedge clk); #1;
        end
        d1 = cyc;
        n_tests++;
        if (done !== 1'b1 || tx_out !== 1'b1 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap: done=%b out=%b rdy=%b, required 1 1 1", done, tx_out, tx_ready);
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int i = 0; i < FC; i++) begin
            n_tests++;
            if (tx_out !== s1[i/4]) begin
                n_fail++;
                $display("FAIL b2b_frame1 cyc%0d: out=%b, required %b", i + 1, tx_out, s1[i/4]);
            end
            @(posedge clk); #1;
        end
        d2 = cyc;
        n_tests++;
        if (done !== 1'b1 || (d2 - d1) !== FC + 1) begin
            n_fail++;
            $display("FAIL b2b_done_spacing: done=%b spacing=%0d, required 1 %0d", done, d2 - d1, FC + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        logic [0:9]    s3c;
        logic [0:NB-1] s5a;
        s3c = 10'b0001111001;
`ifdef SERIAL_TX_PARITY_EN
        s5a = 11'b00101101001;
`else
        s5a = 10'b0010110101;
`endif
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int i = 0; i < 17; i++) begin
            n_tests++;
            if (tx_out !== s3c[i/4]) begin
                n_fail++;
                $display("FAIL rst_mid_pre cyc%0d: out=%b, required %b", i + 1, tx_out, s3c[i/4]);
            end
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: out=%b busy=%b rdy=%b done=%b, required 1 0 1 0",
                     tx_out, busy, tx_ready, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_hold cyc%0d: done=%b busy=%b, required 0 0", i, done, busy);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (tx_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_release: rdy=%b done=%b, required 1 0", tx_ready, done);
        end
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int i = 0; i < FC; i++) begin
            n_tests++;
            if (tx_out !== s5a[i/4] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_mid_5a cyc%0d: out=%b busy=%b, required %b 1", i + 1, tx_out, busy, s5a[i/4]);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (done !== 1'b1 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_5a_done: done=%b rdy=%b, required 1 1", done, tx_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_data_change();
        logic [0:NB-1] s81;
`ifdef SERIAL_TX_PARITY_EN
        s81 = 11'b01000000101;
`else
        s81 = 10'b0100000011;
`endif
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int i = 0; i < FC; i++) begin
            if (i == 10) begin
                tx_data  = 8'h00;
                tx_valid = 1'b1;
            end else if (i == 11) begin
                tx_valid = 1'b0;
            end
            n_tests++;
            if (tx_out !== s81[i/4]) begin
                n_fail++;
                $display("FAIL chg_frame cyc%0d: out=%b, required %b", i + 1, tx_out, s81[i/4]);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL chg_done: done=%b, required 1", done);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (busy !== 1'b0 || tx_out !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL chg_no_second cyc%0d: busy=%b out=%b done=%b, required 0 1 0",
                         i, busy, tx_out, done);
            end
        end
    endtask

`ifdef SERIAL_TX_PARITY_EN
    task automatic test_parity();
        logic [0:10] s07;
        s07 = 11'b01110000011;
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int i = 0; i < 44; i++) begin
            n_tests++;
            if (tx_out !== s07[i/4] || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL parity_frame cyc%0d: out=%b busy=%b done=%b, required %b 1 0",
                         i + 1, tx_out, busy, done, s07[i/4]);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (done !== 1'b1 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_done: done=%b rdy=%b, required 1 1", done, tx_ready);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_reset_mid_frame();
        test_data_change();
`ifdef SERIAL_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
